// File: rtl/ysyx_23060061_pkg.sv
// ysyx_23060061_pkg: shared AXI-Lite response codes, FSM state types and LFSR seed
package ysyx_23060061_pkg;
  typedef enum logic [1:0] {OKAY = 2'b00, DECERR = 2'b11} resp_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2} rstate_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_WAIT = 2'd1, W_RESP = 2'd2} wstate_t;
  localparam logic [3:0] LFSR_SEED = 4'b1001;
endpackage

// File: rtl/ysyx_23060061_lfsr4.sv
// ysyx_23060061_lfsr4: 4-bit maximal-length LFSR (x^4+x^3+1), never reaches zero from a nonzero seed
module ysyx_23060061_lfsr4 (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] seed,
  input  logic       en,
  output logic [3:0] q
);
  // shift left, feeding back the two top taps
  always_ff @(posedge clk)
    q <= rst ? seed : en ? {q[2:0], q[3] ^ q[2]} : q;
endmodule

// File: rtl/ysyx_23060061_axil_sram.sv
// ysyx_23060061_axil_sram: AXI4-Lite SRAM slave with programmable response latency
module ysyx_23060061_axil_sram
  import ysyx_23060061_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter bit          RAND_DELAY  = 1'b0,
  parameter int          FIXED_DELAY = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);
  reg [31:0] mem [0:DEPTH_WORDS-1];
  rstate_t rstate;
  wstate_t wstate;
  logic [3:0] lfsr, dly, rcnt, wcnt, wstrb_q;
  logic [31:0] raddr_q, waddr_q, wdata_q, roff, woff, wmerge;
  logic [AW-1:0] ridx, widx;
  logic rok, wok, aw_got, w_got, aw_nxt, w_nxt, wcommit;
  ysyx_23060061_lfsr4 u_lfsr (.clk(clk), .rst(rst), .seed(LFSR_SEED), .en(1'b1), .q(lfsr));
  assign dly = RAND_DELAY ? lfsr : 4'(FIXED_DELAY);
  assign roff = raddr_q - BASE_ADDR;
  assign woff = waddr_q - BASE_ADDR;
  assign rok = roff < SPAN;
  assign wok = woff < SPAN;
  assign ridx = roff[AW+1:2];
  assign widx = woff[AW+1:2];
  assign arready = rstate == R_IDLE;
  assign rvalid = rstate == R_RESP;
  assign awready = wstate == W_IDLE && !aw_got;
  assign wready = wstate == W_IDLE && !w_got;
  assign bvalid = wstate == W_RESP;
  assign aw_nxt = aw_got | (awvalid & awready);
  assign w_nxt = w_got | (wvalid & wready);
  assign wcommit = wstate == W_WAIT && wcnt == '0 && wok;
  // byte-lane merge of the pending write into the currently stored word
  always_comb begin
    wmerge = mem[widx];
    for (int i = 0; i < 4; i++)
      wmerge[8*i +: 8] = wstrb_q[i] ? wdata_q[8*i +: 8] : mem[widx][8*i +: 8];
  end
  // read FSM; a same-cycle commit to the sampled word is forwarded (write-first)
  always_ff @(posedge clk)
    if (rst) begin
      rstate <= R_IDLE;
      rdata <= '0;
      rresp <= OKAY;
      rcnt <= '0;
      raddr_q <= '0;
    end else begin
      case (rstate)
        R_IDLE: if (arvalid) begin
          raddr_q <= araddr;
          rcnt <= dly;
          rstate <= R_WAIT;
        end
        R_WAIT: if (rcnt == '0) begin
          rdata <= !rok ? '0 : (wcommit && widx == ridx) ? wmerge : mem[ridx];
          rresp <= rok ? OKAY : DECERR;
          rstate <= R_RESP;
        end else rcnt <= rcnt - 4'd1;
        R_RESP: if (rready) rstate <= R_IDLE;
        default: rstate <= R_IDLE;
      endcase
    end
  // write FSM; AW and W are captured independently before the delay starts
  always_ff @(posedge clk)
    if (rst) begin
      wstate <= W_IDLE;
      aw_got <= 1'b0;
      w_got <= 1'b0;
      bresp <= OKAY;
      wcnt <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (awvalid && awready) waddr_q <= awaddr;
          if (wvalid && wready) begin
            wdata_q <= wdata;
            wstrb_q <= wstrb;
          end
          aw_got <= aw_nxt;
          w_got <= w_nxt;
          if (aw_nxt && w_nxt) begin
            wcnt <= dly;
            wstate <= W_WAIT;
          end
        end
        W_WAIT: if (wcnt == '0) begin
          bresp <= wok ? OKAY : DECERR;
          wstate <= W_RESP;
        end else wcnt <= wcnt - 4'd1;
        W_RESP: if (bready) begin
          aw_got <= 1'b0;
          w_got <= 1'b0;
          wstate <= W_IDLE;
        end
        default: wstate <= W_IDLE;
      endcase
    end
  // storage commit; a reset edge discards an uncommitted write
  always_ff @(posedge clk)
    if (!rst && wcommit) mem[widx] <= wmerge;
endmodule
